hwpe_sel_ctrl: RTL

Sequencer that owns the HWPE selection and enable signals of the HWPE subsystem. It accepts HWPE-switch requests from the cluster control unit and drains the active HWPE before changing the selection. Draining means waiting for busy low and no outstanding config-bus transactions. Around the change it holds the clock-gate enable low for a fixed number of cycles. It also stalls new config-bus requests while a switch is in flight, so no transaction reaches a HWPE that is being deselected.

---
 rtl/hwpe_subsys_pkg.sv | 14 +
 rtl/hwpe_outstanding_cnt.sv | 37 +++
 rtl/hwpe_sel_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hwpe_subsys_pkg.sv
// Shared types and constants for the HWPE subsystem control path.
package hwpe_subsys_pkg;

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        DRAIN     = 3'd1,
        GATE_PRE  = 3'd2,
        SWITCH    = 3'd3,
        GATE_POST = 3'd4
    } hwpe_sel_state_e;

    localparam int HWPE_SEL_RESET = 0;

endpackage

// File: rtl/hwpe_outstanding_cnt.sv
// Saturating up/down counter of in-flight bus transactions with full/empty flags.
module hwpe_outstanding_cnt #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [CNT_W-1:0] count_reg, count_next;

    assign full  = (count_reg == CNT_W'(MAX_COUNT));
    assign empty = (count_reg == '0);

    // Simultaneous inc/dec cancel; both ends saturate instead of wrapping.
    always_comb begin
        count_next = count_reg;
        if (inc && !dec && !full) begin
            count_next = count_reg + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/hwpe_sel_ctrl.sv
// HWPE selection sequencer: drains the active HWPE, gates the clock and
// swaps the static mux selection, stalling the config bus while doing so.
module hwpe_sel_ctrl
    import hwpe_subsys_pkg::*;
#(
    parameter int N_HWPES         = 2,
    parameter int SEL_W           = $clog2(N_HWPES),
    parameter int MAX_OUTSTANDING = 4,
    parameter int GATE_CYCLES     = 2,
    parameter int RESET_SEL       = HWPE_SEL_RESET
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sel_req_valid_i,
    input  logic [SEL_W-1:0] sel_req_i,
    output logic             sel_req_ready_o,
    output logic             sel_req_err_o,
    input  logic             cfg_req_i,
    input  logic             cfg_gnt_i,
    input  logic             cfg_rvalid_i,
    output logic             cfg_stall_o,
    input  logic             hwpe_busy_i,
    output logic             hwpe_en_o,
    output logic [SEL_W-1:0] hwpe_sel_o,
    output logic             switching_o
);

    localparam int          GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);
    localparam logic [31:0] N_HWPES_U = 32'(N_HWPES);

    hwpe_sel_state_e  state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] target_reg, target_next;
    logic [GW-1:0]    gate_cnt_reg, gate_cnt_next;
    logic             err_reg, err_next;

    logic accept;
    logic req_in_range;
    logic cfg_inc;
    logic cnt_full;
    logic cnt_empty;

    assign accept       = sel_req_valid_i && sel_req_ready_o;
    assign req_in_range = (32'(sel_req_i) < N_HWPES_U);
    assign cfg_inc      = cfg_req_i && cfg_gnt_i && !cfg_stall_o;

    hwpe_outstanding_cnt #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk   (clk),
        .rst   (rst),
        .inc   (cfg_inc),
        .dec   (cfg_rvalid_i),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    assign sel_req_ready_o = !rst && (state_reg == RUN);
    assign sel_req_err_o   = err_reg;
    assign cfg_stall_o     = cnt_full || (state_reg != RUN);
    assign switching_o     = (state_reg != RUN);
    assign hwpe_sel_o      = sel_reg;

    // The active HWPE keeps its clock while draining so it can finish its job.
    assign hwpe_en_o = !rst && en_i && ((state_reg == RUN) || (state_reg == DRAIN));

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        target_next   = target_reg;
        gate_cnt_next = gate_cnt_reg;
        err_next      = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (accept) begin
                    if (!req_in_range) begin
                        err_next = 1'b1;
                    end else if (sel_req_i != sel_reg) begin
                        target_next = sel_req_i;
                        state_next  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Busy is only trusted here; once gated it may float.
                if (!hwpe_busy_i && cnt_empty) begin
                    state_next    = GATE_PRE;
                    gate_cnt_next = GATE_LOAD;
                end
            end
            GATE_PRE: begin
                if (gate_cnt_reg == '0) begin
                    state_next = SWITCH;
                end else begin
                    gate_cnt_next = gate_cnt_reg - GW'(1);
                end
            end
            SWITCH: begin
                sel_next      = target_reg;
                state_next    = GATE_POST;
                gate_cnt_next = GATE_LOAD;
            end
            GATE_POST: begin
                if (gate_cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    gate_cnt_next = gate_cnt_reg - GW'(1);
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            sel_reg      <= SEL_W'(RESET_SEL);
            target_reg   <= SEL_W'(RESET_SEL);
            gate_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            target_reg   <= target_next;
            gate_cnt_reg <= gate_cnt_next;
            err_reg      <= err_next;
        end
    end

endmodule
